mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port, 512x16 synchronous-read program/data RAM between the instruction-fetch requester (IF stage) and the load/store requester (MEM stage, driven by LW/LW1/SW). Arbitration is per-cycle, with data-side priority and a lock that keeps both words of a 16+16 instruction back-to-back. It also generates per-requester read-valid strobes aligned to the RAM's one-cycle read latency. Sits between the pipeline stage registers and `ram`; the IF stage freezes the PC while `if_gnt` is low.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 16, data width
- `STARVE_MAX`, 3, consecutive denied fetch cycles before fetch is forced (used only with the macro)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request
- `if_addr`  in  AW  fetch address (PC)
- `if_gnt`  out  1  fetch granted this cycle (combinational)
- `if_rvalid`  out  1  `if_rdata` valid (registered)
- `if_rdata`  out  DW  fetched word
- `dm_req`  in  1  data request
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  AW  data address
- `dm_wdata`  in  DW  store data
- `dm_gnt`  out  1  data granted this cycle (combinational)
- `dm_rvalid`  out  1  `dm_rdata` valid; loads only (registered)
- `dm_rdata`  out  DW  loaded word
- `ram_addr`  out  AW  to RAM `addr_in`
- `ram_wdata`  out  DW  to RAM `data_in`
- `ram_we`  out  1  to RAM `write_enable`
- `ram_rdata`  in  DW  from RAM `data_out`

## Operation
- FSM `last`, which records what was issued in the previous cycle: IDLE, IF_RD, DM_RD, DM_WR. Next state is set by this cycle's grant:
  - IF grant → IF_RD
  - DM grant with `dm_we` = 1 → DM_WR
  - DM grant with `dm_we` = 0 → DM_RD
  - no grant → IDLE
- Read-valid strobes:
  - `if_rvalid` = (`last` == IF_RD).
  - `dm_rvalid` = (`last` == DM_RD).
  - DM_WR produces no strobe.
  - `if_rdata` and `dm_rdata` both equal `ram_rdata` unconditionally. Consumers qualify with the strobes.
- BIS lock flag `bis_pend`:
  - `bis_pend` = `if_rvalid` & `ram_rdata[15]` & ~`bis_reg`.
  - `bis_reg` is set when `bis_pend` is granted for fetch, and cleared on the next IF grant.
  - The second word (the immediate) never re-arms the lock, even if its bit 15 = 1.
- Grant priority, highest first:
  1. `bis_pend` & `if_req` → IF
  2. starvation force (macro only) & `if_req` → IF
  3. `dm_req` → DM
  4. `if_req` → IF
- At most one grant per cycle. `if_gnt` and `dm_gnt` are never both 1.
- RAM drive:
  - IF grant: `ram_addr` = `if_addr`, `ram_we` = 0.
  - DM grant: `ram_addr` = `dm_addr`, `ram_wdata` = `dm_wdata`, `ram_we` = `dm_we`.
  - No grant: `ram_addr` = `if_addr`, `ram_we` = 0.
  - `ram_wdata` = `dm_wdata` at all times.
- A requester holds its request and inputs stable until it sees its grant. Withdrawing before grant is legal and has no side effect.
- Address bits above 8 are passed through unchanged. The RAM indexes 0..511.

## Timing
- Grant latency: 0 cycles (combinational).
- Read data: 1 cycle after grant, matching the RAM's registered read.
- Store: the RAM is written on the clock edge ending the grant cycle.
- Back-to-back reads are supported. A new grant is allowed in the same cycle as the previous `rvalid`.
- Simultaneous `if_req` and `dm_req` with no lock or force: DM wins and IF waits.
- Reset (asynchronous, any cycle):
  - `last` = IDLE, `bis_reg` = 0, `starve_cnt` = 0.
  - `if_rvalid` = `dm_rvalid` = 0 immediately.
  - Grants remain combinational from the requests.
  - A read in flight when reset asserts is dropped and its `rvalid` never appears.
- `if_gnt`, `dm_gnt`, and `ram_we` are 0 whenever both requests are low.

## Configuration
- `MEM_ARB_STARVE_EN` defined:
  - 2-bit-plus saturating counter `starve_cnt`, width clog2(`STARVE_MAX`+1).
  - Increments each cycle that `if_req` = 1 and `if_gnt` = 0.
  - Clears on any IF grant, or when `if_req` = 0.
  - When `starve_cnt` == `STARVE_MAX`, IF gets priority over DM that cycle.
- Undefined:
  - Counter is absent and priority is strict DM-over-IF, except for the BIS lock.
  - IF may starve indefinitely under continuous `dm_req`.

## Test plan
- RAM mem[0] = 16'hA120, mem[1] = 16'h007B. `if_req` continuous at addr 0 then 1, `dm_req` = 1 (load, addr 13) arriving the cycle `if_rvalid` shows 16'hA120 → the IF grant for addr 1 wins. `if_rvalid` and 16'h007B follow, then `dm_gnt` the next cycle.
- Both requests in the same cycle, `dm_we` = 1, addr 13, wdata 16'h1234 → `dm_gnt` = 1, `ram_we` = 1. IF is granted the next cycle. A later load of addr 13 returns 16'h1234 with `dm_rvalid` 1 cycle after grant.
- `MEM_ARB_STARVE_EN`, `STARVE_MAX` = 3, both requests held high → DM granted 3 cycles, IF on the 4th, pattern repeating. Without the macro, IF is never granted.
- Load addr 2 (mem = 16'h4332) → `dm_rvalid` = 1 and `dm_rdata` = 16'h4332 exactly one cycle after `dm_gnt`. `if_rvalid` stays 0.
- `reset` asserted mid-cycle right after an IF grant → `if_rvalid` = 0 at once, no strobe after release, `bis_reg` = 0.
- Fetched second word of 16'h8000 (the immediate, bit 15 = 1) → no new lock. A pending `dm_req` wins the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Per-cycle arbiter sharing one 512x16 sync-read RAM between fetch and load/store,
// with data priority, a 16+16 fetch lock and optional fetch anti-starvation (MEM_ARB_STARVE_EN).
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, IF_RD, DM_RD, DM_WR} last_t;

    localparam int SW = $clog2(STARVE_MAX + 1);

    last_t         last;
    logic          bis_reg;
    logic          bis_pend;
    logic          force_if;
    logic [SW-1:0] starve_cnt;

    // A first word with bit 15 set pulls in its immediate before any data access.
    assign bis_pend = if_rvalid & ram_rdata[15] & ~bis_reg;

`ifdef MEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end
`else
    localparam bit STARVE_ON = 1'b0;

    assign starve_cnt = '0;
`endif

    assign force_if = STARVE_ON && (starve_cnt == SW'(STARVE_MAX));

    assign if_gnt = if_req & (bis_pend | force_if | ~dm_req);
    assign dm_gnt = dm_req & ~(if_req & (bis_pend | force_if));

    assign ram_addr  = dm_gnt ? dm_addr : if_addr;
    assign ram_we    = dm_gnt & dm_we;
    assign ram_wdata = dm_wdata;

    assign if_rdata  = ram_rdata;
    assign dm_rdata  = ram_rdata;
    assign if_rvalid = (last == IF_RD);
    assign dm_rvalid = (last == DM_RD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last    <= IDLE;
            bis_reg <= 1'b0;
        end else begin
            if (if_gnt) begin
                last    <= IF_RD;
                bis_reg <= bis_pend;
            end else if (dm_gnt) begin
                last <= dm_we ? DM_WR : DM_RD;
            end else begin
                last <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter: driver pushes expected grants and read data,
// a single monitor process pops and compares on the falling edge.
module tb_mem_port_arbiter;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_IF   = 2'b10;
  localparam logic [1:0] G_DM   = 2'b01;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, ram_we;
  logic [15:0] if_rdata, dm_rdata, ram_addr, ram_wdata, ram_rdata;

  logic [15:0] mem [0:511];

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          done = 1'b0;
  bit          final_done = 1'b0;

  logic [1:0]  gnt_q[$];
  logic [15:0] addr_q[$];
  logic        we_q[$];
  logic [15:0] if_exp_q[$];
  int          if_cyc_q[$];
  logic [15:0] dm_exp_q[$];
  int          dm_cyc_q[$];

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  // clock / reset block and RAM model
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[8:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[8:0]];
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // driver: one bus cycle; eg is the expected {if_gnt,dm_gnt}, erd the read data it returns
  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dwe,
                       input logic [15:0] da, input logic [15:0] dwd, input logic [1:0] eg,
                       input logic [15:0] erd, input logic push);
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
    gnt_q.push_back(eg);
    addr_q.push_back(eg == G_DM ? da : ia);
    we_q.push_back(eg == G_DM && dwe);
    if (push && eg == G_IF) begin
      if_exp_q.push_back(erd);
      if_cyc_q.push_back(cyc + 1);
    end
    if (push && eg == G_DM && !dwe) begin
      dm_exp_q.push_back(erd);
      dm_cyc_q.push_back(cyc + 1);
    end
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, G_NONE, 16'h0, 1'b0);
  endtask

  // monitor / scoreboard
  always begin
    @(negedge clk or posedge reset);
    #1;
    if (reset) begin
      check("rst_if_rvalid", {31'b0, if_rvalid}, 0);
      check("rst_dm_rvalid", {31'b0, dm_rvalid}, 0);
    end else begin
      if (gnt_q.size() > 0) begin
        check("grant", {30'b0, if_gnt, dm_gnt}, {30'b0, gnt_q.pop_front()});
        check("ram_addr", {16'b0, ram_addr}, {16'b0, addr_q.pop_front()});
        check("ram_we", {31'b0, ram_we}, {31'b0, we_q.pop_front()});
        check("ram_wdata", {16'b0, ram_wdata}, {16'b0, dm_wdata});
      end
      if (if_cyc_q.size() > 0 && if_cyc_q[0] == cyc) begin
        void'(if_cyc_q.pop_front());
        check("if_rvalid", {31'b0, if_rvalid}, 1);
        check("if_rdata", {16'b0, if_rdata}, {16'b0, if_exp_q.pop_front()});
      end else if (if_rvalid) begin
        check("if_rvalid_unexpected", 1, 0);
      end
      if (dm_cyc_q.size() > 0 && dm_cyc_q[0] == cyc) begin
        void'(dm_cyc_q.pop_front());
        check("dm_rvalid", {31'b0, dm_rvalid}, 1);
        check("dm_rdata", {16'b0, dm_rdata}, {16'b0, dm_exp_q.pop_front()});
      end else if (dm_rvalid) begin
        check("dm_rvalid_unexpected", 1, 0);
      end
      if (done && !final_done) begin
        check("if_q_drained", if_exp_q.size(), 0);
        check("dm_q_drained", dm_exp_q.size(), 0);
        final_done = 1'b1;
      end
    end
  end

  initial begin
    mem[0]  <= 16'hA120;
    mem[1]  <= 16'h007B;
    mem[2]  <= 16'h4332;
    mem[3]  <= 16'h0003;
    mem[4]  <= 16'h9000;
    mem[5]  <= 16'h8000;
    mem[6]  <= 16'h0111;
    mem[13] <= 16'h0D0D;
    reset = 1'b1;
    if_req = 1'b0; if_addr = 16'h0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = 16'h0; dm_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 16+16 lock: the immediate fetch beats a newly arrived load
    drive(1'b1, 16'd0, 1'b0, 1'b0, 16'd0,  16'h0, G_IF, 16'hA120, 1'b1);
    drive(1'b1, 16'd1, 1'b1, 1'b0, 16'd13, 16'h0, G_IF, 16'h007B, 1'b1);
    drive(1'b1, 16'd2, 1'b1, 1'b0, 16'd13, 16'h0, G_DM, 16'h0D0D, 1'b1);
    drive(1'b1, 16'd2, 1'b0, 1'b0, 16'd0,  16'h0, G_IF, 16'h4332, 1'b1);
    idle();

    // simultaneous store wins, fetch follows, load returns stored word
    drive(1'b1, 16'd3, 1'b1, 1'b1, 16'd13, 16'h1234, G_DM, 16'h0, 1'b1);
    drive(1'b1, 16'd3, 1'b0, 1'b0, 16'd0,  16'h0,    G_IF, 16'h0003, 1'b1);
    drive(1'b0, 16'd0, 1'b1, 1'b0, 16'd13, 16'h0,    G_DM, 16'h1234, 1'b1);
    idle();

    // plain load, and a load with high address bits passed through
    drive(1'b0, 16'd0, 1'b1, 1'b0, 16'd2,    16'h0, G_DM, 16'h4332, 1'b1);
    drive(1'b0, 16'd0, 1'b1, 1'b0, 16'hFE02, 16'h0, G_DM, 16'h4332, 1'b1);
    idle();

    // immediate word with bit 15 set must not re-arm the lock
    drive(1'b1, 16'd4, 1'b0, 1'b0, 16'd0,  16'h0, G_IF, 16'h9000, 1'b1);
    drive(1'b1, 16'd5, 1'b1, 1'b0, 16'd2,  16'h0, G_IF, 16'h8000, 1'b1);
    drive(1'b1, 16'd6, 1'b1, 1'b0, 16'd2,  16'h0, G_DM, 16'h4332, 1'b1);
    drive(1'b1, 16'd6, 1'b0, 1'b0, 16'd0,  16'h0, G_IF, 16'h0111, 1'b1);
    drive(1'b1, 16'd7, 1'b1, 1'b0, 16'd13, 16'h0, G_DM, 16'h1234, 1'b1);
    idle();

    // fetch address bits above 8 pass through to the RAM port
    drive(1'b1, 16'h0201, 1'b0, 1'b0, 16'd0, 16'h0, G_IF, 16'h007B, 1'b1);
    idle();

    // both requests held: strict DM priority, or 3 DM then 1 IF with the starvation guard
    for (int i = 0; i < 8; i++) begin
      logic [1:0] eg;
`ifdef MEM_ARB_STARVE_EN
      eg = (i % 4 == 3) ? G_IF : G_DM;
`else
      eg = G_DM;
`endif
      drive(1'b1, 16'd3, 1'b1, 1'b0, 16'd2, 16'h0, eg, (eg == G_IF) ? 16'h0003 : 16'h4332, 1'b1);
    end
    idle();

    // reset right after a locked fetch grant: its strobe is dropped
    drive(1'b1, 16'd0, 1'b0, 1'b0, 16'd0,  16'h0, G_IF, 16'hA120, 1'b1);
    drive(1'b1, 16'd1, 1'b1, 1'b0, 16'd13, 16'h0, G_IF, 16'h0,    1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle();
    idle();
    drive(1'b1, 16'd0, 1'b0, 1'b0, 16'd0,  16'h0, G_IF, 16'hA120, 1'b1);
    drive(1'b1, 16'd1, 1'b1, 1'b0, 16'd13, 16'h0, G_IF, 16'h007B, 1'b1);
    drive(1'b1, 16'd2, 1'b1, 1'b0, 16'd13, 16'h0, G_DM, 16'h1234, 1'b1);
    idle();
    idle();

    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
